// File: rtl/tick_timer_scheduler.sv
// ---------------------------------------------------------------------------
// tick_timer_scheduler
//
// Multi-channel countdown timer block driven by one shared prescaler tick.
// Each channel counts down on every tic, either one-shot or periodic.
// Expiries are latched as pending flags and drained one at a time through a
// round-robin arbiter into a registered valid/ready event port.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   prescale_div  prescaler terminal value, tic period = prescale_div+1
//   cfg_valid     config command valid
//   cfg_ready     config command ready (low only while in reset)
//   cfg_ch        target channel of the config command
//   cfg_op        00 NOP, 01 START, 10 STOP, 11 CLR_OVR
//   cfg_load      countdown/reload value for START (0 is treated as 1)
//   cfg_periodic  1 = reload on expiry, 0 = one-shot
//   tic           prescaler tick, combinational
//   ch_active     per-channel RUN state
//   ch_overrun    sticky per-channel overrun flags
//   evt_valid     event available
//   evt_ready     event consumer ready
//   evt_ch        channel of the presented event
// ---------------------------------------------------------------------------
module tick_timer_scheduler #(
    parameter int  N_CH  = 4,
    parameter int  PRE_W = 10,
    parameter int  CNT_W = 16,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PRE_W-1:0] prescale_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_op,
    input  logic [CNT_W-1:0] cfg_load,
    input  logic             cfg_periodic,
    output logic             tic,
    output logic [N_CH-1:0]  ch_active,
    output logic [N_CH-1:0]  ch_overrun,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CH_W-1:0]  evt_ch
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_START   = 2'b01,
        OP_STOP    = 2'b10,
        OP_CLR_OVR = 2'b11
    } cfg_op_t;

    localparam logic [CH_W:0] NCH_L = (CH_W+1)'(N_CH);

    // Prescaler
    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_tic;

    // Channel state
    ch_state_t        r_state      [N_CH];
    ch_state_t        w_state_nxt  [N_CH];
    logic [CNT_W-1:0] r_cnt        [N_CH];
    logic [CNT_W-1:0] w_cnt_nxt    [N_CH];
    logic [CNT_W-1:0] r_reload     [N_CH];
    logic [CNT_W-1:0] w_reload_nxt [N_CH];
    logic [N_CH-1:0]  r_periodic;
    logic [N_CH-1:0]  w_periodic_nxt;
    logic [N_CH-1:0]  r_pending;
    logic [N_CH-1:0]  w_pending_nxt;
    logic [N_CH-1:0]  r_overrun;
    logic [N_CH-1:0]  w_overrun_nxt;

    // Config decode
    logic             w_cfg_fire;
    cfg_op_t          w_op;
    logic [CNT_W-1:0] w_start_val;

    // Event output register and arbiter
    logic             r_evt_valid;
    logic [CH_W-1:0]  r_evt_ch;
    logic [CH_W-1:0]  r_rr;
    logic             w_load_en;
    logic             w_any;
    logic             w_take;
    logic [CH_W-1:0]  w_off;
    logic [CH_W-1:0]  w_sel;
    logic [CH_W-1:0]  w_rr_nxt;
    logic [CH_W:0]    w_sum;
    logic [CH_W:0]    w_sel_p1;
    logic [2*N_CH-1:0] w_dbl;
    logic [N_CH-1:0]  w_rot;
    logic [N_CH-1:0]  w_clr;

    // ------------------------------------------------------------------
    // Prescaler: tic is forced low in reset so a zero divider cannot
    // produce a tick while the block is held.
    // ------------------------------------------------------------------
    assign w_tic = rst_n & (r_pre_cnt >= prescale_div);
    assign tic   = w_tic;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (w_tic) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Config port
    // ------------------------------------------------------------------
    assign cfg_ready   = rst_n;
    assign w_cfg_fire  = cfg_valid & rst_n;
    assign w_op        = cfg_op_t'(cfg_op);
    assign w_start_val = (cfg_load == '0) ? CNT_W'(1) : cfg_load;

    // ------------------------------------------------------------------
    // Round-robin pick: rotate pending so bit 0 is the rr pointer, find
    // the first set bit, then map the offset back modulo N_CH.
    // ------------------------------------------------------------------
    assign w_dbl = {r_pending, r_pending} >> r_rr;
    assign w_rot = w_dbl[N_CH-1:0];

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_off = CH_W'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_rr} + {1'b0, w_off};
    assign w_sel     = (w_sum >= NCH_L) ? CH_W'(w_sum - NCH_L) : w_sum[CH_W-1:0];
    assign w_sel_p1  = {1'b0, w_sel} + 1'b1;
    assign w_rr_nxt  = (w_sel_p1 >= NCH_L) ? '0 : w_sel_p1[CH_W-1:0];
    assign w_load_en = ~r_evt_valid | evt_ready;
    assign w_take    = w_load_en & w_any;
    assign w_clr     = w_take ? (N_CH'(1) << w_sel) : '0;

    // ------------------------------------------------------------------
    // Channel next-state. An accepted non-NOP command on a channel takes
    // precedence over that channel's tic. Overrun is judged against the
    // pending bit after this cycle's dequeue, so an expiry of the channel
    // being moved into the output register re-arms pending without an
    // overrun.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_reload_nxt   = r_reload;
        w_periodic_nxt = r_periodic;
        w_pending_nxt  = r_pending & ~w_clr;
        w_overrun_nxt  = r_overrun;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_cfg_fire && (cfg_ch == CH_W'(i)) && (w_op != OP_NOP)) begin
                case (w_op)
                    OP_START: begin
                        w_cnt_nxt[i]      = w_start_val;
                        w_reload_nxt[i]   = w_start_val;
                        w_periodic_nxt[i] = cfg_periodic;
                        w_state_nxt[i]    = ST_RUN;
                    end
                    OP_STOP:    w_state_nxt[i]   = ST_IDLE;
                    OP_CLR_OVR: w_overrun_nxt[i] = 1'b0;
                    default: ;
                endcase
            end else if (w_tic && (r_state[i] == ST_RUN)) begin
                if (r_cnt[i] <= CNT_W'(1)) begin
                    w_overrun_nxt[i] = w_overrun_nxt[i] | w_pending_nxt[i];
                    w_pending_nxt[i] = 1'b1;
                    if (r_periodic[i]) begin
                        w_cnt_nxt[i] = r_reload[i];
                    end else begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_state[i]  <= ST_IDLE;
                r_cnt[i]    <= '0;
                r_reload[i] <= '0;
            end
            r_periodic <= '0;
            r_pending  <= '0;
            r_overrun  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_reload   <= w_reload_nxt;
            r_periodic <= w_periodic_nxt;
            r_pending  <= w_pending_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Event output register: reloads when empty or on the handshake cycle,
    // otherwise holds.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_rr        <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_evt_valid <= 1'b1;
                r_evt_ch    <= w_sel;
                r_rr        <= w_rr_nxt;
            end else begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        ch_active = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_active[i] = (r_state[i] == ST_RUN);
        end
    end

    assign ch_overrun = r_overrun;
    assign evt_valid  = r_evt_valid;
    assign evt_ch     = r_evt_ch;

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tick_timer_scheduler
//
// Bench for tick_timer_scheduler. A behavioural model advances on each
// clock edge from the timer rules and pushes the channel of every event it
// expects to appear on the output port into a scoreboard queue; a separate
// monitor pops that queue on every DUT handshake. Status outputs are
// compared against the model every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_tick_timer_scheduler;

    localparam int N     = 4;
    localparam int PRE_W = 10;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [PRE_W-1:0] prescale_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [1:0]       cfg_op;
    logic [CNT_W-1:0] cfg_load;
    logic             cfg_periodic;
    logic             tic;
    logic [N-1:0]     ch_active;
    logic [N-1:0]     ch_overrun;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_ch;

    tick_timer_scheduler #(
        .N_CH  (N),
        .PRE_W (PRE_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prescale_div (prescale_div),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_op       (cfg_op),
        .cfg_load     (cfg_load),
        .cfg_periodic (cfg_periodic),
        .tic          (tic),
        .ch_active    (ch_active),
        .ch_overrun   (ch_overrun),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pre;
    bit m_run  [N];
    int m_cnt  [N];
    int m_rel  [N];
    bit m_per  [N];
    bit m_pend [N];
    bit m_ovr  [N];
    bit m_ev_v;
    int m_ev_ch;
    int m_rr;
    bit m_tic;
    int m_took;
    int m_c;
    int m_ld;
    int sb_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre = 0; m_ev_v = 0; m_ev_ch = 0; m_rr = 0;
            for (int c = 0; c < N; c++) begin
                m_run[c] = 0; m_cnt[c] = 0; m_rel[c] = 0;
                m_per[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
            end
            sb_q.delete();
        end else begin
            m_tic = (m_pre >= int'(prescale_div));
            // output register takes the next pending channel in rotation
            if (!m_ev_v || evt_ready) begin
                m_took = -1;
                for (int k = 0; k < N; k++) begin
                    m_c = (m_rr + k) % N;
                    if (m_took < 0 && m_pend[m_c]) m_took = m_c;
                end
                if (m_took >= 0) begin
                    m_ev_v = 1; m_ev_ch = m_took; m_rr = (m_took + 1) % N;
                    m_pend[m_took] = 0;
                    sb_q.push_back(m_took);
                end else begin
                    m_ev_v = 0;
                end
            end
            for (int c = 0; c < N; c++) begin
                if (cfg_valid && int'(cfg_ch) == c && cfg_op != 2'd0) begin
                    if (cfg_op == 2'd1) begin
                        m_ld = (cfg_load == 0) ? 1 : int'(cfg_load);
                        m_cnt[c] = m_ld; m_rel[c] = m_ld;
                        m_per[c] = cfg_periodic; m_run[c] = 1;
                    end else if (cfg_op == 2'd2) begin
                        m_run[c] = 0;
                    end else begin
                        m_ovr[c] = 0;
                    end
                end else if (m_tic && m_run[c]) begin
                    if (m_cnt[c] == 1) begin
                        if (m_pend[c]) m_ovr[c] = 1;
                        m_pend[c] = 1;
                        if (m_per[c]) m_cnt[c] = m_rel[c];
                        else          m_run[c] = 0;
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end
            end
            m_pre = m_tic ? 0 : m_pre + 1;
        end
    end

    // ---------------- per-cycle status comparison ----------------
    logic [N-1:0] exp_act;
    logic [N-1:0] exp_ovr;

    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            exp_act[c] = m_run[c];
            exp_ovr[c] = m_ovr[c];
        end
        check("tic", 32'(tic), 32'(rst_n && (m_pre >= int'(prescale_div))));
        check("cfg_ready", 32'(cfg_ready), 32'(rst_n));
        check("ch_active", 32'(ch_active), 32'(exp_act));
        check("ch_overrun", 32'(ch_overrun), 32'(exp_ovr));
        check("evt_valid", 32'(evt_valid), 32'(m_ev_v));
        if (m_ev_v) check("evt_ch_held", 32'(evt_ch), 32'(m_ev_ch));
    end

    // ---------------- scoreboard monitor ----------------
    int mon_exp;
    int ev_seen = 0;
    int seen_q[$];
    int seen_c[$];

    always @(negedge clk) begin
        if (rst_n && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("evt_unexpected", 32'(evt_ch), 32'hFFFF_FFFF);
            end else begin
                mon_exp = sb_q.pop_front();
                check("evt_ch", 32'(evt_ch), 32'(mon_exp));
            end
            seen_q.push_back(int'(evt_ch));
            seen_c.push_back(cyc);
            ev_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic cmd(input int ch, input int op, input int ld, input bit per);
        cfg_valid    = 1'b1;
        cfg_ch       = 2'(ch);
        cfg_op       = 2'(op);
        cfg_load     = 16'(ld);
        cfg_periodic = per;
        step(1);
        cfg_valid = 1'b0;
        cfg_op    = 2'd0;
    endtask

    // returns the number of falling edges until tic is seen, 0 on timeout
    task automatic count_to_tic(output int n);
        n = 0;
        for (int i = 1; i <= 200 && n == 0; i++) begin
            @(negedge clk);
            if (tic === 1'b1) n = i;
        end
        if (n == 0) check("tic_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_order(input string name, input int a, input int b, input int c, input int d);
        check({name, "_count"}, 32'(seen_q.size()), 32'd4);
        if (seen_q.size() == 4) begin
            check({name, "_0"}, 32'(seen_q[0]), 32'(a));
            check({name, "_1"}, 32'(seen_q[1]), 32'(b));
            check({name, "_2"}, 32'(seen_q[2]), 32'(c));
            check({name, "_3"}, 32'(seen_q[3]), 32'(d));
            check({name, "_b2b"}, 32'(seen_c[3] - seen_c[0]), 32'd3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;
    int base;

    initial begin
        rst_n = 1'b1; prescale_div = 10'd3; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_op = '0; cfg_load = '0; cfg_periodic = 1'b0; evt_ready = 1'b1;
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;

        // prescaler: div=3 -> first tic on 4th cycle, then every 4 cycles
        count_to_tic(n);
        check("first_tic_latency", 32'(n), 32'd4);
        count_to_tic(n);
        check("tic_period", 32'(n), 32'd4);
        step(1);
        prescale_div = 10'd0;
        step(4);

        // one-shot
        base = ev_seen; seen_q.delete(); seen_c.delete();
        cmd(1, 1, 5, 1'b0);
        step(10);
        check("oneshot_events", 32'(ev_seen - base), 32'd1);
        if (seen_q.size() > 0) check("oneshot_ch", 32'(seen_q[0]), 32'd1);
        check("oneshot_idle", 32'(ch_active[1]), 32'd0);

        // periodic under backpressure
        evt_ready = 1'b0;
        cmd(0, 1, 2, 1'b1);
        step(8);
        check("ovr_set", 32'(ch_overrun[0]), 32'd1);
        check("held_valid", 32'(evt_valid), 32'd1);
        check("held_ch", 32'(evt_ch), 32'd0);
        cmd(0, 2, 0, 1'b0);
        cmd(0, 3, 0, 1'b0);
        check("ovr_cleared", 32'(ch_overrun[0]), 32'd0);
        base = ev_seen;
        evt_ready = 1'b1;
        step(4);
        check("drain_events", 32'(ev_seen - base), 32'd2);

        // round robin from rr=0 (last event on ch3 wraps the pointer)
        cmd(3, 1, 1, 1'b0);
        step(4);
        prescale_div = 10'd20;
        count_to_tic(n);
        step(1);
        seen_q.delete(); seen_c.delete();
        for (int c = 0; c < N; c++) cmd(c, 1, 3, 1'b0);
        step(80);
        check_order("rr_from0", 0, 1, 2, 3);

        // round robin from rr=2 (last event on ch1)
        prescale_div = 10'd0;
        cmd(1, 1, 1, 1'b0);
        step(4);
        prescale_div = 10'd20;
        count_to_tic(n);
        step(1);
        seen_q.delete(); seen_c.delete();
        for (int c = 0; c < N; c++) cmd(c, 1, 3, 1'b0);
        step(80);
        check_order("rr_from2", 2, 3, 0, 1);

        // START in the tic cycle where ch2 sits at cnt=1 suppresses expiry
        prescale_div = 10'd0;
        base = ev_seen;
        cmd(2, 1, 2, 1'b0);
        step(1);
        cmd(2, 1, 4, 1'b0);
        step(2);
        check("collision_no_expiry", 32'(ev_seen - base), 32'd0);
        step(6);
        check("collision_reload_expiry", 32'(ev_seen - base), 32'd1);

        // STOP on a channel with pending set still delivers its event
        evt_ready = 1'b0;
        cmd(3, 1, 1, 1'b0);
        cmd(2, 1, 1, 1'b0);
        step(2);
        cmd(2, 2, 0, 1'b0);
        seen_q.delete(); seen_c.delete();
        evt_ready = 1'b1;
        step(4);
        check("stop_pend_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("stop_pend_first", 32'(seen_q[0]), 32'd3);
            check("stop_pend_second", 32'(seen_q[1]), 32'd2);
        end

        // asynchronous reset with an event held
        evt_ready = 1'b0;
        cmd(0, 1, 3, 1'b1);
        step(12);
        check("pre_reset_valid", 32'(evt_valid), 32'd1);
        check("pre_reset_active", 32'(ch_active[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_evt_valid", 32'(evt_valid), 32'd0);
        check("arst_ch_active", 32'(ch_active), 32'd0);
        check("arst_ch_overrun", 32'(ch_overrun), 32'd0);
        check("arst_tic", 32'(tic), 32'd0);
        check("arst_cfg_ready", 32'(cfg_ready), 32'd0);
        step(2);
        check("arst_cfg_ready_hold", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_cfg_ready", 32'(cfg_ready), 32'd1);
        step(1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 63) == 0) prescale_div = 10'($urandom_range(0, 4));
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_ch       = 2'($urandom_range(0, 3));
            cfg_op       = 2'($urandom_range(0, 3));
            cfg_load     = 16'($urandom_range(0, 7));
            cfg_periodic = 1'($urandom_range(0, 1));
            evt_ready    = ($urandom_range(0, 9) < 7);
            step(1);
        end

        // stop everything and drain
        cfg_valid = 1'b0;
        evt_ready = 1'b1;
        for (int c = 0; c < N; c++) cmd(c, 2, 0, 1'b0);
        step(20);
        check("final_all_idle", 32'(ch_active), 32'd0);
        check("final_drained", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
